// File: rtl/rvj1_dram_wb_bridge.sv
// Bridges the RVJ1 core data-memory port onto a Wishbone classic master.
// Optional wait-cycle timeout is compiled in with `define RVJ1_DRAM_TIMEOUT_EN.
module rvj1_dram_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  dram_we,
  input  logic        dram_stb,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  output logic [31:0] dram_rdata,
  output logic        dram_ack,
  output logic        dram_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state;
  logic   timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef RVJ1_DRAM_TIMEOUT_EN
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt;

  // Fires on the BUS cycle whose increment would reach the limit, so the
  // bus stays claimed for exactly TIMEOUT_CYCLES cycles.
  assign timeout = ({1'b0, wait_cnt} + 17'd1) == TIMEOUT_LIMIT;
`else
  assign timeout = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // NOTE: the datapath registers (address, data, rdata) are reset too,
      // because the outputs must read zero after reset, not just the controls.
      state      <= IDLE;
      dram_rdata <= '0;
      dram_ack   <= 1'b0;
      dram_err   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
`ifdef RVJ1_DRAM_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          dram_ack <= 1'b0;
          dram_err <= 1'b0;
          if (dram_stb) begin
            wbm_adr_o <= dram_addr;
            wbm_dat_o <= dram_wdata;
            wbm_we_o  <= |dram_we;
            wbm_sel_o <= (|dram_we) ? dram_we : 4'hF;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            state     <= BUS;
`ifdef RVJ1_DRAM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end

        BUS: begin
          // Error (slave or timeout) takes priority over a coincident ack.
          if (wbm_err_i || timeout) begin
            dram_err  <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= RESP;
          end else if (wbm_ack_i) begin
            dram_ack  <= 1'b1;
            if (!wbm_we_o) begin
              dram_rdata <= wbm_dat_i;
            end
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= RESP;
          end else begin
`ifdef RVJ1_DRAM_TIMEOUT_EN
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end

        RESP: begin
          dram_ack <= 1'b0;
          dram_err <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvj1_dram_wb_bridge.sv
// Directed testbench for rvj1_dram_wb_bridge: read, write, ack/err collision,
// timeout (or indefinite wait), reset mid-transfer and back-to-back requests.
module tb_rvj1_dram_wb_bridge;

  logic        clk;
  logic        rst;
  logic [3:0]  dram_we;
  logic        dram_stb;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic        dram_ack;
  logic        dram_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  int checks = 0;
  int errors = 0;

  rvj1_dram_wb_bridge #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .dram_we   (dram_we),
    .dram_stb  (dram_stb),
    .dram_addr (dram_addr),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .dram_ack  (dram_ack),
    .dram_err  (dram_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [104:0] outs;
    rst = 1'b1;
    tick();
    tick();
    outs = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
            dram_rdata, dram_ack, dram_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    dram_stb  = 1'b1;
    dram_we   = 4'h0;
    dram_addr = 32'h3000_0010;
    tick();
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'b110_1111) begin
      errors++;
      $display("FAIL read_ctrl: cyc/stb/we/sel got %b expected 1101111",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
    end
    checks++;
    if (wbm_adr_o !== 32'h3000_0010) begin
      errors++;
      $display("FAIL read_adr: got %h expected 30000010", wbm_adr_o);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({dram_ack, dram_err, wbm_cyc_o} !== 3'b100 || dram_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_resp: ack/err/cyc %b rdata %h expected 100 DEADBEEF",
               {dram_ack, dram_err, wbm_cyc_o}, dram_rdata);
    end
    wbm_ack_i = 1'b0;
    dram_stb  = 1'b0;
    tick();
    checks++;
    if ({dram_ack, dram_err, wbm_cyc_o} !== 3'b000) begin
      errors++;
      $display("FAIL read_ack_pulse: ack/err/cyc got %b expected 000",
               {dram_ack, dram_err, wbm_cyc_o});
    end
  endtask

  task automatic test_wait_states();
    logic ok = 1'b1;
    dram_stb  = 1'b1;
    dram_we   = 4'h0;
    dram_addr = 32'h3000_0020;
    tick();
    dram_stb = 1'b0;
    dram_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      if (!wbm_cyc_o || !wbm_stb_o || dram_ack || dram_err || wbm_adr_o !== 32'h3000_0020)
        ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_hold: bus not held stable during wait states (adr %h)", wbm_adr_o);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0BAD_F00D;
    tick();
    wbm_ack_i = 1'b0;
    checks++;
    if (dram_ack !== 1'b1 || dram_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL wait_resp: ack %b rdata %h expected 1 0BADF00D", dram_ack, dram_rdata);
    end
    tick();
  endtask

  task automatic test_write();
    dram_stb   = 1'b1;
    dram_we    = 4'b0100;
    dram_wdata = 32'h00AB_0000;
    dram_addr  = 32'h3000_0004;
    tick();
    checks++;
    if ({wbm_cyc_o, wbm_we_o, wbm_sel_o} !== 6'b11_0100 || wbm_dat_o !== 32'h00AB_0000
        || wbm_adr_o !== 32'h3000_0004) begin
      errors++;
      $display("FAIL write_ctrl: cyc/we/sel %b dat %h adr %h expected 110100 00AB0000 30000004",
               {wbm_cyc_o, wbm_we_o, wbm_sel_o}, wbm_dat_o, wbm_adr_o);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    tick();
    checks++;
    if (dram_ack !== 1'b1 || dram_err !== 1'b0 || dram_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL write_resp: ack %b err %b rdata %h expected 1 0 0BADF00D",
               dram_ack, dram_err, dram_rdata);
    end
    wbm_ack_i = 1'b0;
    dram_stb  = 1'b0;
    dram_we   = 4'h0;
    tick();
    checks++;
    if (dram_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_pulse: ack got %b expected 0", dram_ack);
    end
  endtask

  task automatic test_ack_err();
    dram_stb  = 1'b1;
    dram_addr = 32'h3000_0030;
    tick();
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    tick();
    checks++;
    if ({dram_ack, dram_err, wbm_cyc_o} !== 3'b010) begin
      errors++;
      $display("FAIL ack_err_priority: ack/err/cyc got %b expected 010",
               {dram_ack, dram_err, wbm_cyc_o});
    end
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    dram_stb  = 1'b0;
    tick();
    checks++;
    if ({dram_ack, dram_err} !== 2'b00) begin
      errors++;
      $display("FAIL ack_err_pulse: ack/err got %b expected 00", {dram_ack, dram_err});
    end
  endtask

  task automatic test_timeout();
    int err_pulses = 0;
    logic held = 1'b1;
    dram_stb  = 1'b1;
    dram_we   = 4'h0;
    dram_addr = 32'h3000_0040;
    tick();
    dram_stb = 1'b0;
`ifdef RVJ1_DRAM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      if (!wbm_cyc_o || dram_err) held = 1'b0;
      tick();
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL timeout_hold: cyc dropped or err early before 4 BUS cycles");
    end
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, dram_err, dram_ack} !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_err: cyc/stb/err/ack got %b expected 0010",
               {wbm_cyc_o, wbm_stb_o, dram_err, dram_ack});
    end
    for (int i = 0; i < 5; i++) begin
      if (dram_err) err_pulses++;
      tick();
    end
    checks++;
    if (err_pulses != 1) begin
      errors++;
      $display("FAIL timeout_pulses: err pulses got %0d expected 1", err_pulses);
    end
`else
    for (int i = 0; i < 120; i++) begin
      if (!wbm_cyc_o || !wbm_stb_o || dram_err || dram_ack) held = 1'b0;
      if (dram_err) err_pulses++;
      tick();
    end
    checks++;
    if (!held || err_pulses != 0) begin
      errors++;
      $display("FAIL no_timeout_hold: bus released within 120 cycles (err pulses %0d)", err_pulses);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE_0001;
    tick();
    wbm_ack_i = 1'b0;
    checks++;
    if (dram_ack !== 1'b1 || dram_rdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL no_timeout_ack: ack %b rdata %h expected 1 CAFE0001", dram_ack, dram_rdata);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid_bus();
    logic [104:0] outs;
    logic quiet = 1'b1;
    dram_stb   = 1'b1;
    dram_we    = 4'b1111;
    dram_wdata = 32'h5555_AAAA;
    dram_addr  = 32'h3000_0050;
    tick();
    tick();
    tick();
    checks++;
    if (wbm_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_bus_setup: cyc got %b expected 1 on 3rd BUS cycle", wbm_cyc_o);
    end
    rst      = 1'b1;
    dram_stb = 1'b0;
    tick();
    outs = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
            dram_rdata, dram_ack, dram_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rst_bus_outputs: got %h expected 0", outs);
    end
    rst       = 1'b0;
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dram_ack || dram_err || wbm_cyc_o) quiet = 1'b0;
    end
    wbm_ack_i = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL rst_bus_discard: ack/err/cyc seen after reset of transfer");
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    dram_stb  = 1'b1;
    dram_we   = 4'h0;
    dram_addr = 32'h3000_0100;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hA5A5_A5A5;
    tick();
    checks++;
    if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0100) begin
      errors++;
      $display("FAIL b2b_first_bus: cyc %b adr %h expected 1 30000100", wbm_cyc_o, wbm_adr_o);
    end
    tick();
    if (dram_ack) acks++;
    checks++;
    if (wbm_cyc_o !== 1'b0 || dram_rdata !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL b2b_first_resp: cyc %b rdata %h expected 0 A5A5A5A5", wbm_cyc_o, dram_rdata);
    end
    dram_addr = 32'h3000_0104;
    wbm_dat_i = 32'h5A5A_5A5A;
    tick();
    if (dram_ack) acks++;
    tick();
    if (dram_ack) acks++;
    checks++;
    if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h3000_0104) begin
      errors++;
      $display("FAIL b2b_second_bus: cyc %b adr %h expected 1 30000104", wbm_cyc_o, wbm_adr_o);
    end
    tick();
    if (dram_ack) acks++;
    checks++;
    if (dram_rdata !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL b2b_second_data: rdata %h expected 5A5A5A5A", dram_rdata);
    end
    dram_stb  = 1'b0;
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dram_ack) acks++;
    end
    checks++;
    if (acks != 2 || wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_count: acks %0d cyc %b expected 2 0", acks, wbm_cyc_o);
    end
  endtask

  initial begin
    rst        = 1'b1;
    dram_we    = 4'h0;
    dram_stb   = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    wbm_dat_i  = '0;
    wbm_ack_i  = 1'b0;
    wbm_err_i  = 1'b0;
    test_reset();
    test_read();
    test_wait_states();
    test_write();
    test_ack_err();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
